fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
Parametrised next-generation fetch stage. Decouples instruction memory from decode with a DEPTH-entry instruction queue and up to MAX_OUTSTANDING pipelined memory requests. Provides a prioritised redirect path and drops stale responses after any redirect. Sits between the instruction memory port and the fetch/decode boundary register, which it owns.

Parameters:
XLEN, 32, address and instruction width
QUEUE_DEPTH, 4, instruction queue entries (power of two, >=2)
MAX_OUTSTANDING, 2, maximum in-flight memory requests (1..QUEUE_DEPTH)
RESET_VECTOR, resetVector from pack, PC value after reset

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
imemReqValid  out  1  fetch request valid
imemReqReady  in  1  memory accepts request
imemReqAddress  out  XLEN  request address (word aligned)
imemRespValid  in  1  response valid; responses return in order
imemRespData  in  XLEN  response instruction word
controlReset  in  1  trap redirect
trapVector  in  XLEN  trap target
mretSignal  in  1  mret redirect, target on branchData
branchValid  in  1  resolved branch redirect
branchData  in  XLEN  branch/mret target
branchPredictValid  in  1  predicted-taken redirect
branchPredictData  in  XLEN  predicted target
fetchDecodeControl  in  control  stall/flush for boundary register
fetchDecodePayload  out  fetchDecodePayload_  boundary register to decode
queueOccupancy  out  clog2(QUEUE_DEPTH)+1  entries held (debug)

Behaviour:
- reset low, asynchronous: fetchPC=RESET_VECTOR; queue empty; outstanding=0; dropCount=0; fetchDecodePayload='0; imemReqValid=0.
- Redirect priority: controlReset > mretSignal > branchValid > branchPredictValid (predict honoured only when !stall). Winner sets fetchPC to target next cycle.
- Any redirect: clears the queue, clears the payload register, sets dropCount = outstanding minus any response arriving that cycle. No request issues in the redirect cycle.
- Issue: imemReqValid = !redirect && (outstanding + occupancy) < QUEUE_DEPTH && outstanding < MAX_OUTSTANDING. On handshake, fetchPC += 4. This credit rule guarantees every response has a free slot; an overflow is an assertion failure.
- Response: if dropCount>0, discard and decrement. Otherwise push {instruction, pc} into the queue; the pc travels with the request in an MAX_OUTSTANDING-deep tag FIFO.
- outstanding: +1 on issue, -1 on response. Simultaneous issue and response leaves it unchanged.
- Boundary register:
  - flush clears valid.
  - Else if !stall: load the queue head (valid=1, instruction, programCounter, programCounterPlus4=pc+4, all modulo 2^XLEN) and pop. If the queue is empty, valid=0.
  - stall holds the register.
- Bypass: a response arriving into an empty queue while the boundary register is loadable is written directly (1-cycle response-to-decode latency). Same-cycle push and pop at full occupancy is legal.
- Mid-operation reset clears everything immediately. Responses to pre-reset requests are the memory's responsibility and are not dropped.

Optional Feature:
FETCH_PERF_COUNTERS_EN: adds outputs perfIssued, perfDropped and perfStarved (32-bit, wrapping, reset 0).
- perfIssued counts request handshakes.
- perfDropped counts discarded responses.
- perfStarved counts cycles where the boundary register is loadable but the queue is empty with no bypass.
Without the macro, the ports and logic are absent.

Decomposition:
- pack: fetchQueueEntry_ struct {instruction, programCounter}, redirectSource_ enum (NONE, TRAP, MRET, BRANCH, PREDICT), and resetVector.
- Sub-module: fetch_queue_fifo (parametrised sync FIFO with push/pop/clear/occupancy), instantiated for the instruction queue and the pc tag FIFO.

Test Plan:
- Reset release, memory always ready, 1-cycle response → requests at 0x0, 0x4, 0x8…; payload valid from cycle 3 with programCounterPlus4 = pc+4.
- Stall held 6 cycles with QUEUE_DEPTH=4 → occupancy saturates at 4 with no issue beyond credit; release drains in order with no loss.
- branchValid to 0x100 with 2 outstanding → both late responses dropped (dropCount 2→0); next payload pc=0x100.
- controlReset and branchValid in the same cycle → pc=trapVector; queue and payload cleared.
- branchPredictValid while stall=1 → ignored; asserted with stall=0 → pc=branchPredictData and queue flushed.
- reset low mid-burst with the queue at 3 → all outputs at reset values asynchronously; fetch resumes at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared types, reset vector and payload helper for the fetch queue unit
package fetch_queue_unit_pkg;

    localparam int FQ_XLEN = 32;
    localparam logic [FQ_XLEN-1:0] resetVector = 32'h0000_0000;

    typedef struct packed {
        logic [FQ_XLEN-1:0] instruction;
        logic [FQ_XLEN-1:0] programCounter;
    } fetchQueueEntry_;

    typedef enum logic [2:0] {
        NONE,
        TRAP,
        MRET,
        BRANCH,
        PREDICT
    } redirectSource_;

    typedef struct packed {
        logic stall;
        logic flush;
    } control_;

    typedef struct packed {
        logic               valid;
        logic [FQ_XLEN-1:0] instruction;
        logic [FQ_XLEN-1:0] programCounter;
        logic [FQ_XLEN-1:0] programCounterPlus4;
    } fetchDecodePayload_;

    function automatic fetchDecodePayload_ to_payload(input fetchQueueEntry_ e);
        fetchDecodePayload_ p;
        p.valid               = 1'b1;
        p.instruction         = e.instruction;
        p.programCounter      = e.programCounter;
        p.programCounterPlus4 = e.programCounter + FQ_XLEN'(4);
        return p;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction memory request/response port bundle
interface fetch_queue_unit_if #(
    parameter int XLEN = 32
);
    logic            imemReqValid;
    logic            imemReqReady;
    logic [XLEN-1:0] imemReqAddress;
    logic            imemRespValid;
    logic [XLEN-1:0] imemRespData;

    modport master (
        output imemReqValid,
        output imemReqAddress,
        input  imemReqReady,
        input  imemRespValid,
        input  imemRespData
    );

    modport slave (
        input  imemReqValid,
        input  imemReqAddress,
        output imemReqReady,
        output imemRespValid,
        output imemRespData
    );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// rtl/fetch_queue_unit_fifo.sv - fetch_queue_fifo: synchronous FIFO with clear, head peek and occupancy
module fetch_queue_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    occupancy_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign occupancy_o = count_q;
    assign head_o      = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch stage with instruction queue, redirects and stale-response drop; FETCH_PERF_COUNTERS_EN adds perf counters
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int              XLEN            = FQ_XLEN,
    parameter int              QUEUE_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR    = resetVector
) (
    input  logic                         clock,
    input  logic                         reset,
    fetch_queue_unit_if.master           imem,
    input  logic                         controlReset,
    input  logic [XLEN-1:0]              trapVector,
    input  logic                         mretSignal,
    input  logic                         branchValid,
    input  logic [XLEN-1:0]              branchData,
    input  logic                         branchPredictValid,
    input  logic [XLEN-1:0]              branchPredictData,
    input  control_                      fetchDecodeControl,
    output fetchDecodePayload_           fetchDecodePayload,
    output logic [$clog2(QUEUE_DEPTH):0] queueOccupancy
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                  perfIssued,
    output logic [31:0]                  perfDropped,
    output logic [31:0]                  perfStarved
`endif
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(QUEUE_DEPTH) + 1;
    localparam int TW = $clog2(MAX_OUTSTANDING) + 1;

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]      outstanding_q, outstanding_d;
    logic [OW-1:0]      drop_q, drop_d;
    fetchDecodePayload_ payload_q, payload_d;

    redirectSource_     redirect_src;
    logic [XLEN-1:0]    redirect_target;
    logic               redirect, stall, flush;
    logic               issue_ok, req_fire, resp_dec, resp_drop, resp_accept;
    logic               loadable, bypass;
    fetchQueueEntry_    resp_entry, q_head;
    logic [QW-1:0]      q_occ;
    logic               q_push, q_pop, q_empty, q_full;
    logic [XLEN-1:0]    tag_head;
    logic [TW-1:0]      tag_occ;
    logic               tag_empty, tag_full;

    assign stall = fetchDecodeControl.stall;
    assign flush = fetchDecodeControl.flush;

    always_comb begin
        redirect_src    = NONE;
        redirect_target = '0;
        if (controlReset) begin
            redirect_src    = TRAP;
            redirect_target = trapVector;
        end else if (mretSignal) begin
            redirect_src    = MRET;
            redirect_target = branchData;
        end else if (branchValid) begin
            redirect_src    = BRANCH;
            redirect_target = branchData;
        end else if (branchPredictValid && !stall) begin
            redirect_src    = PREDICT;
            redirect_target = branchPredictData;
        end
    end

    assign redirect = (redirect_src != NONE);

    // Credit counts queue slots already promised to in-flight requests, so a response always finds room.
    assign issue_ok = reset && !redirect
                      && ((int'(outstanding_q) + int'(q_occ)) < QUEUE_DEPTH)
                      && (int'(outstanding_q) < MAX_OUTSTANDING);
    assign req_fire = issue_ok && imem.imemReqReady;

    assign resp_dec    = imem.imemRespValid && (outstanding_q != '0);
    assign resp_drop   = imem.imemRespValid && (drop_q != '0);
    assign resp_accept = imem.imemRespValid && (drop_q == '0) && !redirect;
    assign resp_entry  = '{instruction: imem.imemRespData, programCounter: tag_head};

    assign loadable = !redirect && !flush && !stall;
    assign bypass   = loadable && q_empty && resp_accept;
    assign q_push   = resp_accept && !bypass;
    assign q_pop    = loadable && !q_empty;

    fetch_queue_fifo #(
        .WIDTH($bits(fetchQueueEntry_)),
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (redirect),
        .push_i      (q_push),
        .push_data_i (resp_entry),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .occupancy_o (q_occ),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    // Stale requests leave the tag FIFO on redirect; drop_q tracks their responses instead.
    fetch_queue_fifo #(
        .WIDTH(XLEN),
        .DEPTH(MAX_OUTSTANDING)
    ) u_tags (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (redirect),
        .push_i      (req_fire),
        .push_data_i (fetch_pc_q),
        .pop_i       (resp_accept),
        .head_o      (tag_head),
        .occupancy_o (tag_occ),
        .empty_o     (tag_empty),
        .full_o      (tag_full)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        payload_d     = payload_q;

        if (redirect)      fetch_pc_d = redirect_target;
        else if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);

        case ({req_fire, resp_dec})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect)       drop_d = outstanding_q - OW'(resp_dec);
        else if (resp_drop) drop_d = drop_q - OW'(1);

        if (redirect) begin
            payload_d = '0;
        end else if (flush) begin
            payload_d.valid = 1'b0;
        end else if (!stall) begin
            if (!q_empty)         payload_d = to_payload(q_head);
            else if (resp_accept) payload_d = to_payload(resp_entry);
            else                  payload_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_q        <= '0;
            payload_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            payload_q     <= payload_d;
        end
    end

    assign imem.imemReqValid   = issue_ok;
    assign imem.imemReqAddress = fetch_pc_q;
    assign fetchDecodePayload  = payload_q;
    assign queueOccupancy      = q_occ;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_issued_q, perf_dropped_q, perf_starved_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issued_q  <= '0;
            perf_dropped_q <= '0;
            perf_starved_q <= '0;
        end else begin
            if (req_fire)                             perf_issued_q  <= perf_issued_q + 32'd1;
            if (resp_drop || (imem.imemRespValid && redirect))
                                                      perf_dropped_q <= perf_dropped_q + 32'd1;
            if (loadable && q_empty && !bypass)       perf_starved_q <= perf_starved_q + 32'd1;
        end
    end

    assign perfIssued  = perf_issued_q;
    assign perfDropped = perf_dropped_q;
    assign perfStarved = perf_starved_q;
`endif

    a_no_queue_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(q_push && q_full && !q_pop));
    a_no_tag_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(req_fire && tag_full && !resp_accept));
    a_tag_tracks_credit: assert property (@(posedge clock) disable iff (!reset)
        (int'(tag_occ) == int'(outstanding_q) - int'(drop_q)) && (tag_empty == (tag_occ == '0)));

endmodule
